prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5: the frame-start byte.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_data, input, 8 bits: the loader byte stream.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data holds a byte.
REQ-006 SHALL have port rx_ready, output, 1 bit: the loader accepts the byte; a transfer occurs when rx_valid and rx_ready are both high at a clock edge.
REQ-007 SHALL have port addr, input, 4 bits: the CPU program counter.
REQ-008 SHALL have port dout, output, 8 bits: the instruction at addr.
REQ-009 SHALL have port cpu_run, output, 1 bit: drives the CPU active-low reset; 0 holds the CPU in reset.
REQ-010 SHALL have port loading, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port err, output, 1 bit: the last frame was rejected.

Function
REQ-012 SHALL hold a 16x8 program memory; dout = mem[addr] combinationally, and a read coincident with a write returns the old value.
REQ-013 SHALL drive rx_ready = 1 in every state except the cycle in which reset is high.
REQ-014 SHALL implement FSM states IDLE, LEN, DATA, CHECK.
REQ-015 IDLE: on accepted byte == HDR_BYTE, SHALL go to LEN and set loading=1 and cpu_run=0 next cycle; SHALL ignore any other byte.
REQ-016 LEN: on accepted byte, SHALL treat the byte as count N.
REQ-017 LEN: for N in 1..16, SHALL clear ptr and cks and go to DATA.
REQ-018 LEN: for any other N, including 0 and N>16, SHALL set err=1 and loading=0, go to IDLE, and keep cpu_run=0.
REQ-019 DATA: on each accepted byte, SHALL write mem[ptr]=byte, set cks ^= byte and increment ptr; after the Nth byte SHALL go to CHECK (with macro) or to completion (without macro).
REQ-020 DATA SHALL treat HDR_BYTE as ordinary data, with no resynchronisation mid-frame.
REQ-021 Completion SHALL set err=0, loading=0 and cpu_run=1 on the same edge and return to IDLE; the CPU then restarts at PC 0.
REQ-022 CHECK: an accepted byte equal to cks SHALL cause completion.
REQ-023 CHECK: on mismatch, SHALL set err=1 and loading=0, go to IDLE, and keep cpu_run=0; written bytes stay in memory.
REQ-024 Locations ptr >= N SHALL retain their prior contents.
REQ-025 Once cleared by a rejected frame, cpu_run SHALL stay 0 until a frame completes or reset.
REQ-026 With no rx_valid, the FSM SHALL hold its state indefinitely, with no timeout.

Reset
REQ-027 reset high SHALL, at the clock edge: clear all 16 memory locations to 8'h00 (MOV r0,r0, a NOP), set state=IDLE, ptr=0, cks=0, loading=0, err=0 and cpu_run=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; partially written bytes are cleared by REQ-027.

Configuration
REQ-029 With macro PROG_LOADER_CKSUM_EN defined, SHALL include the CHECK state and the XOR checksum byte per REQ-022/023.
REQ-030 Without PROG_LOADER_CKSUM_EN, SHALL omit the CHECK state and cks register; a frame completes after the Nth data byte, and err is set only by REQ-018.

Structure
REQ-031 Package dl166_pkg SHALL hold PROG_DEPTH=16, the default HDR_BYTE value, and the loader state enum type.
REQ-032 Memory SHALL be a sub-module prog_ram: 16x8, synchronous write with enable, asynchronous read, synchronous clear.

Verification
REQ-033 Reset, then addr sweep 0..15 -> dout=8'h00 at every address; cpu_run=1, err=0, loading=0.
REQ-034 Frame A5,03,A1,92,45, then cks 76 (with macro) -> mem[0..2]=A1,92,45; cpu_run 0 from the edge after A5 until completion, then 1; err=0.
REQ-035 Same frame with cks 77 (with macro) -> err=1, cpu_run stays 0; a following good frame restores cpu_run=1 and err=0.
REQ-036 Frame A5,00 and frame A5,11 -> each gives err=1, state IDLE, no memory write.
REQ-037 Bytes 3C,A5,01,A5,A5 (with macro) -> 3C ignored; mem[0]=A5; checksum A5 accepted; mem[1..15] unchanged.
REQ-038 Reset pulsed after 2 of 4 data bytes, with rx_valid gaps of 0-3 cycles throughout -> memory all 00, cpu_run=1, next frame loads correctly.

Source files
------------

// File: rtl/dl166_pkg.sv
// Shared constants and types for the program loader.
// The checksum feature is enabled by defining PROG_LOADER_CKSUM_EN.
`timescale 1ns/1ps
package dl166_pkg;

    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W = 4;
    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEN   = 2'd1,
        ST_DATA  = 2'd2
`ifdef PROG_LOADER_CKSUM_EN
        ,
        ST_CHECK = 2'd3
`endif
    } loader_state_t;

    // A frame length is legal when it fits the program memory and is non-empty.
    function automatic logic len_ok(input logic [7:0] n);
        return (n >= 8'd1) && (n <= 8'(PROG_DEPTH));
    endfunction

endpackage

// File: rtl/prog_ram.sv
// 16x8 program memory: synchronous write with enable, asynchronous read,
// synchronous clear. A read coincident with a write returns the old value.
`timescale 1ns/1ps
module prog_ram
    import dl166_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives HDR, N, N data bytes (and an XOR checksum
// when PROG_LOADER_CKSUM_EN is defined), fills program memory and holds the CPU in reset while loading.
`timescale 1ns/1ps
module prog_loader
    import dl166_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [3:0] addr,
    output logic [7:0] dout,
    output logic       cpu_run,
    output logic       loading,
    output logic       err,
    output logic [1:0] state
);

    // Handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
    // the loader is always ready except while reset is high.
    logic take;

    loader_state_t state_q, state_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [3:0]    last_q, last_d;
    logic          loading_q, loading_d;
    logic          err_q, err_d;
    logic          run_q, run_d;
    logic          we;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]    cks_q, cks_d;
`endif

    assign rx_ready = ~reset;
    assign take     = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            last_q    <= '0;
            loading_q <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
            cks_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            loading_q <= loading_d;
            err_q     <= err_d;
            run_q     <= run_d;
`ifdef PROG_LOADER_CKSUM_EN
            cks_q     <= cks_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        loading_d = loading_q;
        err_d     = err_q;
        run_d     = run_q;
        we        = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
        cks_d     = cks_q;
`endif
        if (take) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == HDR_BYTE) begin
                        state_d   = ST_LEN;
                        loading_d = 1'b1;
                        run_d     = 1'b0;
                    end
                end
                ST_LEN: begin
                    if (len_ok(rx_data)) begin
                        // last index is N-1; N=16 wraps 0-1 to 15 in four bits
                        ptr_d   = '0;
                        last_d  = rx_data[3:0] - 4'd1;
                        state_d = ST_DATA;
`ifdef PROG_LOADER_CKSUM_EN
                        cks_d   = '0;
`endif
                    end else begin
                        err_d     = 1'b1;
                        loading_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 4'd1;
`ifdef PROG_LOADER_CKSUM_EN
                    cks_d = cks_q ^ rx_data;
                    if (ptr_q == last_q) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (ptr_q == last_q) begin
                        err_d     = 1'b0;
                        loading_d = 1'b0;
                        run_d     = 1'b1;
                        state_d   = ST_IDLE;
                    end
`endif
                end
`ifdef PROG_LOADER_CKSUM_EN
                ST_CHECK: begin
                    loading_d = 1'b0;
                    state_d   = ST_IDLE;
                    if (rx_data == cks_q) begin
                        err_d = 1'b0;
                        run_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    prog_ram u_ram (
        .clk   (clk),
        .clear (reset),
        .we    (we),
        .waddr (ptr_q),
        .wdata (rx_data),
        .raddr (addr),
        .rdata (dout)
    );

    assign cpu_run = run_q;
    assign loading = loading_q;
    assign err     = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a memory model and an expected-byte queue.
// Checksum steps follow PROG_LOADER_CKSUM_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       cpu_run;
    logic       loading;
    logic       err;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_mem [16];
    logic [7:0] exp_q [$];
    logic [7:0] frame_buf [16];

    prog_loader #(.HDR_BYTE(HDR)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .addr     (addr),
        .dout     (dout),
        .cpu_run  (cpu_run),
        .loading  (loading),
        .err      (err),
        .state    (state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic run_e, input logic err_e,
                                input logic load_e, input logic [1:0] st_e);
        check8({tag, " cpu_run"}, {7'd0, cpu_run}, {7'd0, run_e});
        check8({tag, " err"}, {7'd0, err}, {7'd0, err_e});
        check8({tag, " loading"}, {7'd0, loading}, {7'd0, load_e});
        check8({tag, " state"}, {6'd0, state}, {6'd0, st_e});
    endtask

    // driver: present one byte after `gap` idle cycles; time is always posedge+1
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check8("rx_ready before transfer", {7'd0, rx_ready}, 8'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    // sends a complete well-formed frame from frame_buf and updates the model
    task automatic load_frame(input string tag, input int n, input int max_gap);
        logic [7:0] c;
        c = 8'h00;
        send_byte(HDR, pick_gap(max_gap));
        check_status({tag, " after hdr"}, 1'b0, err, 1'b1, 2'd1);
        send_byte(8'(n), pick_gap(max_gap));
        for (int i = 0; i < n; i++) begin
            send_byte(frame_buf[i], pick_gap(max_gap));
            c = c ^ frame_buf[i];
            exp_mem[i] = frame_buf[i];
`ifdef PROG_LOADER_CKSUM_EN
            check8({tag, " run low in data"}, {7'd0, cpu_run}, 8'd0);
`else
            if (i < n - 1) check8({tag, " run low in data"}, {7'd0, cpu_run}, 8'd0);
`endif
        end
`ifdef PROG_LOADER_CKSUM_EN
        send_byte(c, pick_gap(max_gap));
`endif
        check_status({tag, " done"}, 1'b1, 1'b0, 1'b0, 2'd0);
    endtask

    // scoreboard: push the model image, then sweep addr and pop/compare
    task automatic check_mem(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_mem[i]);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            addr = 4'(i);
            #1;
            e = exp_q.pop_front();
            check8($sformatf("%s mem[%0d]", tag, i), dout, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        addr     = 4'd0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check8("rx_ready in reset", {7'd0, rx_ready}, 8'd0);
        reset = 1'b0;
        check_status("reset", 1'b1, 1'b0, 1'b0, 2'd0);
        check_mem("reset");

        // basic 3-byte frame, cks 76
        frame_buf[0] = 8'hA1; frame_buf[1] = 8'h92; frame_buf[2] = 8'h45;
        load_frame("frameA", 3, 0);
        check_mem("frameA");

`ifdef PROG_LOADER_CKSUM_EN
        // same frame with a bad checksum: rejected, bytes stay written
        send_byte(HDR, 0);
        send_byte(8'h03, 1);
        send_byte(8'hA1, 0);
        send_byte(8'h92, 2);
        send_byte(8'h45, 0);
        send_byte(8'h77, 3);
        check_status("bad cks", 1'b0, 1'b1, 1'b0, 2'd0);
        check_mem("bad cks");
`endif

        // shorter frame: locations at and above N keep frameA bytes
        frame_buf[0] = 8'h11; frame_buf[1] = 8'h22;
        load_frame("frame2", 2, 1);
        check_mem("frame2 retain");

        // illegal lengths 0 and 0x11
        send_byte(HDR, 0);
        send_byte(8'h00, 0);
        check_status("len 00", 1'b0, 1'b1, 1'b0, 2'd0);
        send_byte(HDR, 2);
        send_byte(8'h11, 1);
        check_status("len 11", 1'b0, 1'b1, 1'b0, 2'd0);
        check_mem("bad len");

        // stray byte in idle, then HDR used as data (and as checksum)
        send_byte(8'h3C, 0);
        check_status("stray 3C", 1'b0, 1'b1, 1'b0, 2'd0);
        send_byte(HDR, 0);
        send_byte(8'h01, 0);
        send_byte(HDR, 0);
`ifdef PROG_LOADER_CKSUM_EN
        check8("hdr as data state", {6'd0, state}, 8'd3);
        send_byte(HDR, 0);
`endif
        exp_mem[0] = HDR;
        check_status("hdr as data", 1'b1, 1'b0, 1'b0, 2'd0);
        check_mem("hdr as data");

        // reset in mid-frame with random gaps
        send_byte(HDR, pick_gap(3));
        send_byte(8'h04, pick_gap(3));
        send_byte(8'hDE, pick_gap(3));
        send_byte(8'hAD, pick_gap(3));
        check8("mid-frame loading", {7'd0, loading}, 8'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        check_status("mid reset", 1'b1, 1'b0, 1'b0, 2'd0);
        check_mem("mid reset");

        for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        load_frame("full frame", 16, 3);
        check_mem("full frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
